instruction_fetch_unit: RTL and testbench
=========================================

Name: instruction_fetch_unit

Overview:
- Owns the architectural program counter and fetches one instruction at a time from instruction memory over a ready-based handshake.
- Consumes the next-PC value produced by the branch/PC-generation stage (programCounterInput) when control signals that the current instruction is complete.
- Supplies the held instruction word and its PC (pcOfInstruction) to decode and the branch/PC-generation stage.
- Detects misaligned next-PC targets and instruction-memory timeouts, and halts on either.

Parameters:
- RESET_VECTOR, 32'h00000000, PC value loaded on reset; must be 4-byte aligned.
- FETCH_TIMEOUT, 255, max consecutive FETCH cycles with imemReady low before a timeout halt; 0 disables the timeout.

Ports:
- clock  input  1  core clock, all state updates on rising edge
- reset  input  1  asynchronous, active-low reset
- programCounterInput  input  32  next PC from branch/PC-generation stage
- advance  input  1  control: current instruction finished, load programCounterInput
- imemAddress  output  32  fetch address (equals PC)
- imemRequest  output  1  fetch request
- imemReady  input  1  memory: imemData valid this cycle
- imemData  input  32  instruction word from memory
- instruction  output  32  held instruction word
- pcOfInstruction  output  32  PC of held instruction
- instructionValid  output  1  instruction/pcOfInstruction valid for execution
- fetchMisaligned  output  1  sticky: halted on misaligned target
- fetchTimeout  output  1  sticky: halted on memory timeout
- halted  output  1  sticky: unit in HALT

Behaviour:
- Reset (reset low, asynchronous):
  - pc=RESET_VECTOR, state=FETCH, timeout counter=0.
  - instruction=32'h00000013 (nop); instructionValid=0.
  - fetchMisaligned=0, fetchTimeout=0, halted=0.
  - Effect is immediate, without a clock edge. Reset mid-fetch abandons the request; no data is captured.
- imemAddress=pc and pcOfInstruction=pc at all times.
- FETCH state:
  - imemRequest=1, instructionValid=0.
  - On an edge with imemReady=1: instruction<=imemData, instructionValid<=1, counter<=0, go to EXECUTE.
  - Otherwise the counter increments. If FETCH_TIMEOUT!=0 and the counter reaches FETCH_TIMEOUT, go to HALT with fetchTimeout<=1.
  - First request is asserted in the first cycle after reset deasserts.
  - Zero-wait memory (imemReady high in the request cycle) captures on that edge.
- EXECUTE state:
  - imemRequest=0, instructionValid=1; instruction and pc are held stable.
  - On an edge with advance=1 and programCounterInput[1:0]==2'b00: pc<=programCounterInput, instructionValid<=0, go to FETCH.
  - On an edge with advance=1 and programCounterInput[1:0]!=0: go to HALT, fetchMisaligned<=1. pc and instruction are unchanged, so the faulting PC stays visible.
- HALT state:
  - imemRequest=0, instructionValid=0, halted=1.
  - Leaves only by reset. advance and imemReady are ignored.
- Out-of-state inputs: advance outside EXECUTE is ignored; imemReady outside FETCH is ignored.
- Latency:
  - advance edge -> imemRequest high with new address on the next cycle.
  - Minimum 2 cycles per instruction (1 FETCH + 1 EXECUTE) with zero-wait memory.
- Arithmetic: PC is 32 bits, no increment here; wrap-around is whatever the upstream stage supplies. Timeout counter is 8 bits wide minimum and saturates.
- Error flags: set simultaneously with halted, never both.

Optional Feature:
- Macro: INSTRUCTION_FETCH_RETIRED_COUNTER_EN.
- Defined: adds output port retiredCount (64 bits), reset to 0. Increments by 1 on each accepted aligned advance in EXECUTE and wraps at 2^64. Misaligned advances and HALT do not count.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
1. Reset boot: RESET_VECTOR=0; release reset, hold imemReady low 3 cycles, then high with imemData=32'h00500093.
   - Required: imemRequest=1 and imemAddress=0 through the wait.
   - Required next cycle: instruction=32'h00500093, instructionValid=1, pcOfInstruction=0, imemRequest=0.
2. Advance: in EXECUTE pulse advance with programCounterInput=32'h00000004.
   - Required next cycle: imemRequest=1, imemAddress=4, instructionValid=0.
   - Required: zero-wait ready then gives instructionValid=1 one cycle later.
3. Misaligned: in EXECUTE at pc=8, advance with programCounterInput=32'h00000006.
   - Required: halted=1, fetchMisaligned=1, fetchTimeout=0, pcOfInstruction stays 8, imemRequest=0.
   - Required: later imemReady/advance pulses cause no change.
4. Timeout: FETCH_TIMEOUT=4, imemReady held low.
   - Required: halted=1 and fetchTimeout=1 after the 4th FETCH edge, then imemRequest=0.
   - Required: with FETCH_TIMEOUT=0, no halt after 1000 cycles.
5. Async reset mid-wait: assert reset between clock edges during FETCH.
   - Required: outputs immediately return to reset values (instruction=32'h00000013, instructionValid=0, imemAddress=RESET_VECTOR).
6. Counter (macro defined): 3 aligned advances and 1 misaligned advance.
   - Required: retiredCount=3; it resets to 0 on reset.

Source files
------------

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: PC owner fetching one instruction at a time; optional retiredCount via INSTRUCTION_FETCH_RETIRED_COUNTER_EN
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_VECTOR  = 32'h00000000,
    parameter int          FETCH_TIMEOUT = 255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] programCounterInput,
    input  logic        advance,
    output logic [31:0] imemAddress,
    output logic        imemRequest,
    input  logic        imemReady,
    input  logic [31:0] imemData,
    output logic [31:0] instruction,
    output logic [31:0] pcOfInstruction,
    output logic        instructionValid,
    output logic        fetchMisaligned,
    output logic        fetchTimeout,
`ifdef INSTRUCTION_FETCH_RETIRED_COUNTER_EN
    output logic [63:0] retiredCount,
`endif
    output logic        halted
);
    localparam logic [1:0] FETCH   = 2'd0;
    localparam logic [1:0] EXECUTE = 2'd1;
    localparam logic [1:0] HALT    = 2'd2;
    localparam int CW = FETCH_TIMEOUT > 255 ? $clog2(FETCH_TIMEOUT + 1) : 8;
    localparam logic [31:0] NOP = 32'h00000013;

    logic [1:0]    state;
    logic [31:0]   pc;
    logic [CW-1:0] waitCount;
    logic [CW-1:0] waitNext;
    logic          capture;
    logic          accept;
    logic          misTarget;
    logic          timeoutHit;

    // next-state conditions for the fetch handshake, advance and timeout
    always_comb begin
        capture    = state == FETCH && imemReady;
        waitNext   = &waitCount ? waitCount : waitCount + 1'b1;
        timeoutHit = state == FETCH && !imemReady && FETCH_TIMEOUT != 0 && waitNext == CW'(FETCH_TIMEOUT);
        accept     = state == EXECUTE && advance && programCounterInput[1:0] == 2'b00;
        misTarget  = state == EXECUTE && advance && programCounterInput[1:0] != 2'b00;
    end

    // state machine: FETCH -> EXECUTE -> FETCH, any fault parks in HALT until reset
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            state <= FETCH;
        else if (capture)
            state <= EXECUTE;
        else if (timeoutHit || misTarget)
            state <= HALT;
        else if (accept)
            state <= FETCH;
    end

    // PC only moves on an accepted aligned advance, so a faulting target never becomes visible
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            pc <= RESET_VECTOR;
        else if (accept)
            pc <= programCounterInput;
    end

    // instruction register captures memory data on the ready edge of a fetch
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            instruction <= NOP;
        else if (capture)
            instruction <= imemData;
    end

    // saturating count of consecutive FETCH cycles without ready
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            waitCount <= '0;
        else if (state == FETCH)
            waitCount <= capture ? '0 : waitNext;
    end

    // sticky fault flags, raised together with the transition into HALT
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            fetchMisaligned <= 1'b0;
            fetchTimeout    <= 1'b0;
        end else begin
            fetchMisaligned <= fetchMisaligned | misTarget;
            fetchTimeout    <= fetchTimeout | timeoutHit;
        end
    end

`ifdef INSTRUCTION_FETCH_RETIRED_COUNTER_EN
    // retired instruction count, one per accepted aligned advance, wraps naturally
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            retiredCount <= 64'd0;
        else if (accept)
            retiredCount <= retiredCount + 64'd1;
    end
`endif

    assign imemAddress      = pc;
    assign pcOfInstruction  = pc;
    assign imemRequest      = state == FETCH;
    assign instructionValid = state == EXECUTE;
    assign halted           = state == HALT;
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb_instruction_fetch_unit: scoreboard bench for the fetch unit, its timeout limits and async reset
module tb_instruction_fetch_unit;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        resetB = 1'b1;
    logic [31:0] pcIn = 32'h0;
    logic        advance = 1'b0;
    logic        imemReady = 1'b0;
    logic [31:0] imemData = 32'h0;
    logic [31:0] imemAddress, instruction, pcOfInstruction;
    logic        imemRequest, instructionValid, fetchMisaligned, fetchTimeout, halted;
`ifdef INSTRUCTION_FETCH_RETIRED_COUNTER_EN
    logic [63:0] retiredCount, retiredA, retiredB;
`endif
    logic [31:0] addrA, instrA, pcA, addrB, instrB, pcB;
    logic        reqA, validA, misA, toA, haltA, reqB, validB, misB, toB, haltB;
    logic        timeoutDone = 1'b0;

    int total = 0;
    int bad = 0;
    logic [63:0] expQ[$];

    localparam logic [31:0] X1 = 32'h00500093;
    localparam logic [31:0] X2 = 32'h00a00113;
    localparam logic [31:0] X3 = 32'h00208193;
    localparam logic [31:0] X4 = 32'h00000297;

    always #5 clock = ~clock;

    instruction_fetch_unit #(.RESET_VECTOR(32'h0), .FETCH_TIMEOUT(255)) dut (
        .clock(clock), .reset(reset), .programCounterInput(pcIn), .advance(advance),
        .imemAddress(imemAddress), .imemRequest(imemRequest), .imemReady(imemReady), .imemData(imemData),
        .instruction(instruction), .pcOfInstruction(pcOfInstruction), .instructionValid(instructionValid),
        .fetchMisaligned(fetchMisaligned), .fetchTimeout(fetchTimeout),
`ifdef INSTRUCTION_FETCH_RETIRED_COUNTER_EN
        .retiredCount(retiredCount),
`endif
        .halted(halted));

    instruction_fetch_unit #(.RESET_VECTOR(32'h0), .FETCH_TIMEOUT(4)) dutA (
        .clock(clock), .reset(resetB), .programCounterInput(32'h0), .advance(1'b0),
        .imemAddress(addrA), .imemRequest(reqA), .imemReady(1'b0), .imemData(32'h0),
        .instruction(instrA), .pcOfInstruction(pcA), .instructionValid(validA),
        .fetchMisaligned(misA), .fetchTimeout(toA),
`ifdef INSTRUCTION_FETCH_RETIRED_COUNTER_EN
        .retiredCount(retiredA),
`endif
        .halted(haltA));

    instruction_fetch_unit #(.RESET_VECTOR(32'h0), .FETCH_TIMEOUT(0)) dutB (
        .clock(clock), .reset(resetB), .programCounterInput(32'h0), .advance(1'b0),
        .imemAddress(addrB), .imemRequest(reqB), .imemReady(1'b0), .imemData(32'h0),
        .instruction(instrB), .pcOfInstruction(pcB), .instructionValid(validB),
        .fetchMisaligned(misB), .fetchTimeout(toB),
`ifdef INSTRUCTION_FETCH_RETIRED_COUNTER_EN
        .retiredCount(retiredB),
`endif
        .halted(haltB));

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic fetchWord(input logic [31:0] data, input logic [31:0] pc);
        imemReady = 1'b1;
        imemData  = data;
        expQ.push_back({data, pc});
        tick();
        imemReady = 1'b0;
        check("validAfterCapture", {63'd0, instructionValid}, 64'd1);
        check("reqAfterCapture", {63'd0, imemRequest}, 64'd0);
    endtask

    task automatic doAdvance(input logic [31:0] target);
        advance = 1'b1;
        pcIn    = target;
        tick();
        advance = 1'b0;
    endtask

    // monitor: every rising instructionValid must match the oldest expected {instruction, pc}
    initial begin
        logic prevValid;
        logic [63:0] e;
        prevValid = 1'b0;
        forever begin
            @(negedge clock);
            if (instructionValid && !prevValid) begin
                if (expQ.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpectedValid actual=%h required=none", {instruction, pcOfInstruction});
                end else begin
                    e = expQ.pop_front();
                    check("scoreInstr", {32'd0, instruction}, {32'd0, e[63:32]});
                    check("scorePc", {32'd0, pcOfInstruction}, {32'd0, e[31:0]});
                end
            end
            prevValid = instructionValid;
        end
    end

    // timeout limit checks on the side instances
    initial begin
        #2 resetB = 1'b0;
        @(negedge clock);
        resetB = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            tick();
            check("toBeforeLimitHalt", {63'd0, haltA}, 64'd0);
            check("toBeforeLimitReq", {63'd0, reqA}, 64'd1);
        end
        tick();
        check("toHalted", {63'd0, haltA}, 64'd1);
        check("toFlag", {63'd0, toA}, 64'd1);
        check("toNoMis", {63'd0, misA}, 64'd0);
        check("toReqLow", {63'd0, reqA}, 64'd0);
        repeat (1000) tick();
        check("noTimeoutHalt", {63'd0, haltB}, 64'd0);
        check("noTimeoutFlag", {63'd0, toB}, 64'd0);
        check("noTimeoutReq", {63'd0, reqB}, 64'd1);
        timeoutDone = 1'b1;
    end

    initial begin
        #2 reset = 1'b0;
        #1;
        check("rstInstr", {32'd0, instruction}, 64'h13);
        check("rstValid", {63'd0, instructionValid}, 64'd0);
        check("rstAddr", {32'd0, imemAddress}, 64'd0);
        check("rstHalted", {61'd0, halted, fetchMisaligned, fetchTimeout}, 64'd0);
`ifdef INSTRUCTION_FETCH_RETIRED_COUNTER_EN
        check("rstRetired", retiredCount, 64'd0);
`endif
        @(negedge clock);
        reset = 1'b1;
        check("bootReq", {63'd0, imemRequest}, 64'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("waitReq", {63'd0, imemRequest}, 64'd1);
            check("waitAddr", {32'd0, imemAddress}, 64'd0);
        end
        fetchWord(X1, 32'h0);
        doAdvance(32'h4);
        check("advReq", {63'd0, imemRequest}, 64'd1);
        check("advAddr", {32'd0, imemAddress}, 64'd4);
        check("advValid", {63'd0, instructionValid}, 64'd0);
        fetchWord(X2, 32'h4);
        doAdvance(32'h8);
        fetchWord(X3, 32'h8);
        doAdvance(32'h6);
        check("misHalted", {63'd0, halted}, 64'd1);
        check("misFlags", {62'd0, fetchMisaligned, fetchTimeout}, 64'd2);
        check("misPc", {32'd0, pcOfInstruction}, 64'd8);
        check("misReq", {63'd0, imemRequest}, 64'd0);
        check("misValid", {63'd0, instructionValid}, 64'd0);
        imemReady = 1'b1;
        imemData  = X4;
        advance   = 1'b1;
        pcIn      = 32'h10;
        repeat (3) tick();
        imemReady = 1'b0;
        advance   = 1'b0;
        check("haltStayHalted", {63'd0, halted}, 64'd1);
        check("haltStayPc", {32'd0, pcOfInstruction}, 64'd8);
        check("haltStayInstr", {32'd0, instruction}, {32'd0, X3});
        check("haltStayReq", {62'd0, imemRequest, instructionValid}, 64'd0);
`ifdef INSTRUCTION_FETCH_RETIRED_COUNTER_EN
        check("retiredTwo", retiredCount, 64'd2);
`endif
        reset = 1'b0;
        #1 reset = 1'b1;
        fetchWord(X4, 32'h0);
        doAdvance(32'h20);
        tick();
        check("midWaitAddr", {32'd0, imemAddress}, 64'h20);
        #2 reset = 1'b0;
        #1;
        check("asyncInstr", {32'd0, instruction}, 64'h13);
        check("asyncValid", {63'd0, instructionValid}, 64'd0);
        check("asyncAddr", {32'd0, imemAddress}, 64'd0);
        check("asyncPc", {32'd0, pcOfInstruction}, 64'd0);
        check("asyncHalted", {63'd0, halted}, 64'd0);
        @(negedge clock);
        reset = 1'b1;
        fetchWord(X1, 32'h0);
        doAdvance(32'h4);
        fetchWord(X2, 32'h4);
        doAdvance(32'h8);
        fetchWord(X3, 32'h8);
        doAdvance(32'hc);
        fetchWord(X4, 32'hc);
        doAdvance(32'h6);
        check("cntMis", {63'd0, fetchMisaligned}, 64'd1);
        check("cntPc", {32'd0, pcOfInstruction}, 64'hc);
`ifdef INSTRUCTION_FETCH_RETIRED_COUNTER_EN
        check("retiredThree", retiredCount, 64'd3);
`endif
        reset = 1'b0;
        #1;
`ifdef INSTRUCTION_FETCH_RETIRED_COUNTER_EN
        check("retiredReset", retiredCount, 64'd0);
`endif
        check("finalRstHalted", {63'd0, halted}, 64'd0);
        @(negedge clock);
        reset = 1'b1;
        tick();
        check("queueDrained", 64'(expQ.size()), 64'd0);
        for (int i = 0; i < 2000 && !timeoutDone; i++) tick();
        check("timeoutSideDone", {63'd0, timeoutDone}, 64'd1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
